// File: rtl/serial_add_controller_pkg.sv
// Shared constants for the serial adder sequencer: FSM encodings, default widths
// and the signed-overflow rule applied to the captured result.
package serial_add_controller_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    // Overflow when both operands share a sign and the sum's sign differs from it.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_add_controller_if.sv
// Operand and result channels of the sequencer. Both channels use valid/ready:
// a transfer happens on a posedge where valid and ready are both high.
interface serial_add_controller_if
    import serial_add_controller_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/serial_add_controller_bit_counter.sv
// Counts bit-serial adder cycles; done flags the last of WIDTH cycles.
module serial_add_controller_bit_counter
    import serial_add_controller_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/serial_add_controller.sv
// Sequencer for a bit-serial adder: accepts an operand pair, loads and clocks the
// adder for WIDTH cycles, then captures and holds the result until it is taken.
module serial_add_controller
    import serial_add_controller_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_add_controller_if.slave io,
    output logic                 add_load,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout,
    output logic                 busy,
    output logic [2:0]           dbg_state
);
    logic [2:0]       state;
    logic             cnt_done;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_cout_q;
    logic             out_ovf_q;

    serial_add_controller_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == S_LOAD),
        .en   (state == S_RUN),
        .done (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            add_a       <= '0;
            add_b       <= '0;
            add_cin     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (io.in_valid) begin
                        add_a   <= io.in_a;
                        add_b   <= io.in_b;
                        add_cin <= io.in_cin;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: state <= S_RUN;
                S_RUN: begin
                    if (cnt_done) state <= S_CAPT;
                end
                S_CAPT: begin
                    out_sum_q   <= add_sum;
                    out_cout_q  <= add_cout;
                    out_ovf_q   <= signed_ovf(add_a[WIDTH-1], add_b[WIDTH-1], add_sum[WIDTH-1]);
                    out_valid_q <= 1'b1;
                    state       <= S_HOLD;
                end
                S_HOLD: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The adder reloads continuously while idle, so only LOAD's edge matters.
    assign add_load     = (state == S_IDLE) || (state == S_LOAD);
    assign busy         = (state != S_IDLE);
    assign dbg_state    = state;
    assign io.in_ready  = (state == S_IDLE);
    assign io.out_valid = out_valid_q;
    assign io.out_sum   = out_sum_q;
    assign io.out_cout  = out_cout_q;
    assign io.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_serial_add_controller.sv
// Directed bench for serial_add_controller driving a behavioural bit-serial adder.
module tb_serial_add_controller;
    logic       clk;
    logic       rst;
    logic       add_load;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_sum;
    logic       add_cout;
    logic       busy;
    logic [2:0] dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [9:0] exp_q[$];

    serial_add_controller_if #(.WIDTH(8)) io ();

    serial_add_controller #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .io        (io),
        .add_load  (add_load),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural serial_bit_adder, LSB first, one bit per non-load edge
    logic [7:0] m_a, m_b, m_sum;
    logic       m_cy;
    int         m_idx;
    always @(posedge clk) begin
        if (add_load) begin
            m_a   <= add_a;
            m_b   <= add_b;
            m_cy  <= add_cin;
            m_sum <= 8'h00;
            m_idx <= 0;
        end else if (m_idx < 8) begin
            m_sum[m_idx] <= m_a[m_idx] ^ m_b[m_idx] ^ m_cy;
            m_cy  <= (m_a[m_idx] & m_b[m_idx]) | (m_a[m_idx] & m_cy) | (m_b[m_idx] & m_cy);
            m_idx <= m_idx + 1;
        end
    end
    assign add_sum  = m_sum;
    assign add_cout = m_cy;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           output bit ok);
        int guard;
        guard = 0;
        io.in_a     = a;
        io.in_b     = b;
        io.in_cin   = cin;
        io.in_valid = 1'b1;
        while (!io.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        ok = io.in_ready;
        tick();
        io.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!io.out_valid && edges < 30) begin
            tick();
            edges++;
        end
    endtask

    task automatic consume();
        io.out_ready = 1'b1;
        tick();
        io.out_ready = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({io.in_ready, add_load, io.out_valid, busy} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL reset_flags got ready/load/valid/busy=%b want 1100",
                     {io.in_ready, add_load, io.out_valid, busy});
        end
        tests_run++;
        if ({io.out_sum, io.out_cout, io.out_ovf} !== 10'h000) begin
            tests_failed++;
            $display("FAIL reset_result got sum=%h cout=%b ovf=%b want 00 0 0",
                     io.out_sum, io.out_cout, io.out_ovf);
        end
        tests_run++;
        if ({add_a, add_b, add_cin, dbg_state} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_adder got a=%h b=%h cin=%b st=%0d want 0",
                     add_a, add_b, add_cin, dbg_state);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_add();
        bit ok;
        int edges;
        send_op(8'h24, 8'h84, 1'b0, ok);
        tests_run++;
        if (!ok || dbg_state !== 3'd1 || add_load !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_accept got ok=%0d st=%0d load=%b want 1 1 1", ok, dbg_state, add_load);
        end
        tick();
        tests_run++;
        if (add_load !== 1'b0 || busy !== 1'b1 || add_a !== 8'h24 || add_b !== 8'h84) begin
            tests_failed++;
            $display("FAIL basic_run got load=%b busy=%b a=%h b=%h want 0 1 24 84",
                     add_load, busy, add_a, add_b);
        end
        wait_valid(edges);
        edges = edges + 1;
        tests_run++;
        if (edges !== 10) begin
            tests_failed++;
            $display("FAIL basic_latency got %0d edges want 10", edges);
        end
        tests_run++;
        if ({io.out_ovf, io.out_cout, io.out_sum} !== {2'b00, 8'hA8}) begin
            tests_failed++;
            $display("FAIL basic_result got ovf=%b cout=%b sum=%h want 0 0 a8",
                     io.out_ovf, io.out_cout, io.out_sum);
        end
        consume();
        tests_run++;
        if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_release got valid=%b ready=%b want 0 1", io.out_valid, io.in_ready);
        end
    endtask

    task automatic test_carry_overflow();
        bit ok;
        int edges;
        send_op(8'hFF, 8'h01, 1'b0, ok);
        wait_valid(edges);
        tests_run++;
        if (!io.out_valid || {io.out_ovf, io.out_cout, io.out_sum} !== {2'b01, 8'h00}) begin
            tests_failed++;
            $display("FAIL carry_result got v=%b ovf=%b cout=%b sum=%h want 1 0 1 00",
                     io.out_valid, io.out_ovf, io.out_cout, io.out_sum);
        end
        consume();
        send_op(8'h7F, 8'h01, 1'b0, ok);
        wait_valid(edges);
        tests_run++;
        if (!io.out_valid || {io.out_ovf, io.out_cout, io.out_sum} !== {2'b10, 8'h80}) begin
            tests_failed++;
            $display("FAIL ovf_result got v=%b ovf=%b cout=%b sum=%h want 1 1 0 80",
                     io.out_valid, io.out_ovf, io.out_cout, io.out_sum);
        end
        consume();
    endtask

    task automatic test_hold_backpressure();
        bit ok;
        int edges;
        int bad;
        send_op(8'h11, 8'h22, 1'b0, ok);
        wait_valid(edges);
        io.in_a     = 8'h55;
        io.in_b     = 8'h55;
        io.in_cin   = 1'b1;
        io.in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (io.out_valid !== 1'b1 || io.out_sum !== 8'h33 || io.in_ready !== 1'b0 ||
                add_a !== 8'h11 || dbg_state !== 3'd4)
                bad++;
            tick();
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL hold_stable got %0d bad cycles want 0 (sum=%h ready=%b a=%h)",
                     bad, io.out_sum, io.in_ready, add_a);
        end
        io.in_valid = 1'b0;
        consume();
        tick();
        tests_run++;
        if (busy !== 1'b0 || io.out_valid !== 1'b0 || add_a !== 8'h11) begin
            tests_failed++;
            $display("FAIL hold_no_second got busy=%b valid=%b a=%h want 0 0 11",
                     busy, io.out_valid, add_a);
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        int edges;
        int seen;
        send_op(8'hAA, 8'h55, 1'b0, ok);
        for (int i = 0; i < 5; i++) tick();
        tests_run++;
        if (dbg_state !== 3'd2) begin
            tests_failed++;
            $display("FAIL midrst_in_run got st=%0d want 2", dbg_state);
        end
        rst = 1'b1;
        io.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        io.out_ready = 1'b0;
        tests_run++;
        if (dbg_state !== 3'd0 || busy !== 1'b0 || io.in_ready !== 1'b1 || add_a !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_idle got st=%0d busy=%b ready=%b a=%h want 0 0 1 00",
                     dbg_state, busy, io.in_ready, add_a);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (io.out_valid) seen++;
            tick();
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL midrst_dropped got %0d valid cycles want 0", seen);
        end
        send_op(8'h10, 8'h20, 1'b1, ok);
        wait_valid(edges);
        tests_run++;
        if (!io.out_valid || {io.out_ovf, io.out_cout, io.out_sum} !== {2'b00, 8'h31}) begin
            tests_failed++;
            $display("FAIL midrst_after got v=%b ovf=%b cout=%b sum=%h want 1 0 0 31",
                     io.out_valid, io.out_ovf, io.out_cout, io.out_sum);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [7:0] op_a[3];
        logic [7:0] op_b[3];
        logic       op_c[3];
        logic [9:0] exp;
        int cyc, n_acc, n_res, last_acc;
        bit acc;
        op_a = '{8'h01, 8'h80, 8'hC3};
        op_b = '{8'h02, 8'h80, 8'h3C};
        op_c = '{1'b0, 1'b1, 1'b0};
        exp_q.push_back(10'h003);
        exp_q.push_back(10'h301);
        exp_q.push_back(10'h0FF);
        cyc = 0; n_acc = 0; n_res = 0; last_acc = 0;
        io.in_a = op_a[0]; io.in_b = op_b[0]; io.in_cin = op_c[0];
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        while (n_res < 3 && cyc < 100) begin
            acc = io.in_ready && io.in_valid;
            if (io.out_valid) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
                n_res++;
                tests_run++;
                if ({io.out_ovf, io.out_cout, io.out_sum} !== exp) begin
                    tests_failed++;
                    $display("FAIL b2b_result%0d got %h want %h", n_res,
                             {io.out_ovf, io.out_cout, io.out_sum}, exp);
                end
            end
            tick();
            cyc++;
            if (acc) begin
                if (n_acc > 0) begin
                    tests_run++;
                    if (cyc - last_acc !== 12) begin
                        tests_failed++;
                        $display("FAIL b2b_interval got %0d cycles want 12", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                n_acc++;
                if (n_acc < 3) begin
                    io.in_a = op_a[n_acc]; io.in_b = op_b[n_acc]; io.in_cin = op_c[n_acc];
                end else begin
                    io.in_valid = 1'b0;
                end
            end
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        tests_run++;
        if (n_res !== 3 || n_acc !== 3) begin
            tests_failed++;
            $display("FAIL b2b_count got acc=%0d res=%0d want 3 3", n_acc, n_res);
        end
    endtask

    initial begin
        rst          = 1'b1;
        io.in_valid  = 1'b0;
        io.in_a      = 8'h00;
        io.in_b      = 8'h00;
        io.in_cin    = 1'b0;
        io.out_ready = 1'b0;
        test_reset();
        test_basic_add();
        test_carry_overflow();
        test_hold_backpressure();
        test_reset_midflight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
